axis_video_out: RTL and testbench
=================================

# axis_video_out

Final pixel stage downstream of the RGB565→RGB888 expander. Consumes its AXI4-Stream video (one pixel per beat, {R,G,B,8'h00}, tuser = start of frame, tlast = end of line) and drives native parallel video: free-running raster timing, hsync/vsync/de, and 24-bit RGB. A small elastic FIFO absorbs upstream jitter. Frame lock is acquired on SOF and dropped on underflow or misalignment.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync, in lines
- HSYNC_POL / VSYNC_POL, 0 / 0, asserted level of sync (0 = active-low)
- FIFO_DEPTH, 16, elastic FIFO entries, power of two, ≥4
- vid_aclk  in  1  pixel clock; sole clock
- vid_aresetn  in  1  asynchronous, active-low reset
- s_axis_vid_tdata  in  32  [31:24] R, [23:16] G, [15:8] B, [7:0] ignored
- s_axis_vid_tuser  in  1  start of frame, on first pixel of frame
- s_axis_vid_tlast  in  1  end of line, on last pixel of each line
- s_axis_vid_tvalid  in  1  beat valid
- s_axis_vid_tready  out  1  = FIFO not full
- vid_data  out  24  {R,G,B}; 0 whenever vid_de = 0 or no valid pixel
- vid_de  out  1  active video
- vid_hsync / vid_vsync  out  1  sync, polarity per parameter
- locked  out  1  high in LOCKED state
- underflow  out  1  one-cycle pulse, FIFO empty on a needed pixel
- resync_err  out  1  one-cycle pulse, tuser/tlast misaligned with raster

## Operation
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params), v_cnt 0..V_TOTAL-1. Both free-run from reset regardless of lock. v_cnt increments when h_cnt wraps.
- Raster: active when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines.
- FIFO: width 26, entries {tuser, tlast, tdata[31:8]}. Writes on tvalid && tready. Pops are controlled by the state machine.
- WAIT_SOF (reset state):
  - A non-empty head without tuser is popped every cycle (discard).
  - A head with tuser → WAIT_FRAME, without popping it.
- WAIT_FRAME:
  - Hold the head.
  - When h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1 → LOCKED.
- LOCKED:
  - Pops one entry per active raster cycle.
  - Expected flags: tuser = (h_cnt=0 && v_cnt=0); tlast = (h_cnt = H_ACTIVE-1).
  - FIFO empty on an active cycle: output pixel is 0, underflow pulses → WAIT_SOF.
  - Popped flags ≠ expected: output pixel is 0, resync_err pulses → WAIT_SOF. The popped entry is consumed.
- Outside LOCKED, vid_data = 0. Timing outputs keep running.
- Simultaneous write and pop on a full FIFO: tready is already 0, so no write occurs. Write and pop on a non-empty, non-full FIFO both take effect.

## Timing
- All outputs are registered. vid_de/hsync/vsync/vid_data reflect counter state one cycle earlier. vid_data is aligned with vid_de.
- First locked pixel appears on the cycle after counters wrap to (0,0), plus 1 register stage.
- Input-to-FIFO latency: 1 cycle. tready is a registered full flag, so the FIFO never overflows.
- Reset values: tready 0 during reset, then 1; vid_de 0; vid_data 0; syncs deasserted (= ~POL); locked 0; underflow 0; resync_err 0.
- Asserting reset mid-frame clears counters, FIFO pointers and state immediately (asynchronous).
- underflow and resync_err never assert in the same cycle; underflow takes priority.

## Structure
- Shared video package holds:
  - the state enum (WAIT_SOF, WAIT_FRAME, LOCKED)
  - a timing-parameter struct/constants for the default 640×480 mode
  - the pixel field-slice constants for the {R,G,B,pad} layout used by the expander
- One sub-module: `video_sync_fifo` (single-clock, registered full/empty, show-ahead head).
- Timing counters and FSM stay in the top module.

## Test plan
Bench parameters: H 4/1/2/1, V 3/1/1/1 (48 cycles/frame), FIFO_DEPTH 4.
- No input after reset → hsync low 2 of every 8 cycles; de high 4 cycles × 3 lines per 48; vsync low 1 line; vid_data 0; locked 0.
- One frame, tdata = {idx,idx,idx,8'h00} for idx 1..12, tuser on 1, tlast on 4/8/12 → locked rises at wrap; vid_data = 0x010101..0x0C0C0C in de order; no error pulses.
- 5 beats without tuser, then the frame above → junk dropped with tready=1 throughout; output identical to the previous scenario.
- tvalid dropped after pixel 6 → 7th de cycle vid_data 0, underflow one-cycle pulse, locked falls; next full frame relocks.
- tlast on pixel 3 → resync_err pulse at that pixel, locked 0, relock on next frame; reset asserted at pixel 8 of a later frame → all outputs at reset values immediately.
- Continuous 3-frame stream, upstream always valid → tready toggles at FIFO full; no beat lost or duplicated across all 36 pixels.

Source files
------------

// File: rtl/axis_video_out_pkg.sv
// -----------------------------------------------------------------------------
// axis_video_out_pkg
// Shared definitions for the video output path:
//   - vid_state_e   : frame-lock state machine encoding
//   - vid_timing_t  : raster timing set, with the default 640x480 mode
//   - PIX_*         : field slices of the {R,G,B,pad} 32-bit pixel word produced
//                     by the RGB565->RGB888 expander
//   - fifo_entry_t  : elastic FIFO entry {sof, eol, rgb}
// -----------------------------------------------------------------------------
package axis_video_out_pkg;

   typedef enum logic [1:0] {
      WAIT_SOF   = 2'd0,
      WAIT_FRAME = 2'd1,
      LOCKED     = 2'd2
   } vid_state_e;

   typedef struct packed {
      int unsigned h_active;
      int unsigned h_fp;
      int unsigned h_sync;
      int unsigned h_bp;
      int unsigned v_active;
      int unsigned v_fp;
      int unsigned v_sync;
      int unsigned v_bp;
   } vid_timing_t;

   localparam vid_timing_t VGA_640X480 = '{
      h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
      v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
   };

   // {R,G,B,pad} layout of the 32-bit stream word
   localparam int PIX_R_HI   = 31;
   localparam int PIX_R_LO   = 24;
   localparam int PIX_G_HI   = 23;
   localparam int PIX_G_LO   = 16;
   localparam int PIX_B_HI   = 15;
   localparam int PIX_B_LO   = 8;
   localparam int PIX_PAD_HI = 7;
   localparam int PIX_PAD_LO = 0;

   localparam int RGB_W = 24;

   typedef struct packed {
      logic             sof;   // tuser of the beat
      logic             eol;   // tlast of the beat
      logic [RGB_W-1:0] rgb;   // {R,G,B}
   } fifo_entry_t;

   localparam int FIFO_W = $bits(fifo_entry_t);

endpackage

// File: rtl/video_sync_fifo.sv
// -----------------------------------------------------------------------------
// video_sync_fifo
// Single-clock elastic FIFO with show-ahead head and registered status flags.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset (clears pointers and flags)
//   wr_valid_i : write request; takes effect only while ready_o is high
//   wr_data_i  : write data
//   ready_o    : registered "not full"; low during reset
//   rd_en_i    : pop request; ignored while empty_o is high
//   rd_data_o  : current head entry (valid whenever empty_o is low)
//   empty_o    : registered empty flag
// -----------------------------------------------------------------------------
module video_sync_fifo #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_valid_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic             ready_o,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;
   logic             ready_q;
   logic             empty_q;
   logic             push;
   logic             pop;

   // A write while full is impossible because ready_q already reads 0.
   assign push = wr_valid_i & ready_q;
   assign pop  = rd_en_i & ~empty_q;

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         ready_q <= (count_d != FULL_CNT);
         empty_q <= (count_d == '0);
      end
   end

   // Storage is not reset; only pointers define validity.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   // Show-ahead: head is always presented without a read request.
   assign rd_data_o = mem_q[rd_ptr_q];
   assign ready_o   = ready_q;
   assign empty_o   = empty_q;

endmodule

// File: rtl/axis_video_out.sv
// -----------------------------------------------------------------------------
// axis_video_out
// AXI4-Stream video (one {R,G,B,pad} pixel per beat, tuser = SOF, tlast = EOL)
// to native parallel video with a free-running raster and frame lock.
//   vid_aclk / vid_aresetn : pixel clock, asynchronous active-low reset
//   s_axis_vid_*           : stream input; tready = registered FIFO not-full
//   vid_data               : {R,G,B}, zero outside active/locked pixels
//   vid_de, vid_hsync, vid_vsync : raster timing (sync polarity by parameter)
//   locked                 : high while in the LOCKED state
//   underflow              : 1-cycle pulse, FIFO empty on a needed pixel
//   resync_err             : 1-cycle pulse, tuser/tlast disagree with raster
// All outputs are registered and reflect the raster position of the previous
// cycle.
// -----------------------------------------------------------------------------
module axis_video_out
   import axis_video_out_pkg::*;
#(
   parameter int H_ACTIVE   = VGA_640X480.h_active,
   parameter int H_FP       = VGA_640X480.h_fp,
   parameter int H_SYNC     = VGA_640X480.h_sync,
   parameter int H_BP       = VGA_640X480.h_bp,
   parameter int V_ACTIVE   = VGA_640X480.v_active,
   parameter int V_FP       = VGA_640X480.v_fp,
   parameter int V_SYNC     = VGA_640X480.v_sync,
   parameter int V_BP       = VGA_640X480.v_bp,
   parameter bit HSYNC_POL  = 1'b0,
   parameter bit VSYNC_POL  = 1'b0,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              vid_aclk,
   input  logic              vid_aresetn,
   input  logic [31:0]       s_axis_vid_tdata,
   input  logic              s_axis_vid_tuser,
   input  logic              s_axis_vid_tlast,
   input  logic              s_axis_vid_tvalid,
   output logic              s_axis_vid_tready,
   output logic [RGB_W-1:0]  vid_data,
   output logic              vid_de,
   output logic              vid_hsync,
   output logic              vid_vsync,
   output logic              locked,
   output logic              underflow,
   output logic              resync_err
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   // ---------------------------------------------------------------- FIFO
   fifo_entry_t      wr_entry;
   fifo_entry_t      head;
   logic [FIFO_W-1:0] fifo_rd_data;
   logic             fifo_empty;
   logic             fifo_pop;
   logic             unused_pad;

   assign wr_entry.sof = s_axis_vid_tuser;
   assign wr_entry.eol = s_axis_vid_tlast;
   assign wr_entry.rgb = {s_axis_vid_tdata[PIX_R_HI:PIX_R_LO],
                          s_axis_vid_tdata[PIX_G_HI:PIX_G_LO],
                          s_axis_vid_tdata[PIX_B_HI:PIX_B_LO]};
   assign unused_pad   = ^s_axis_vid_tdata[PIX_PAD_HI:PIX_PAD_LO];

   video_sync_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (vid_aclk),
      .rst_ni     (vid_aresetn),
      .wr_valid_i (s_axis_vid_tvalid),
      .wr_data_i  (wr_entry),
      .ready_o    (s_axis_vid_tready),
      .rd_en_i    (fifo_pop),
      .rd_data_o  (fifo_rd_data),
      .empty_o    (fifo_empty)
   );

   assign head = fifo_entry_t'(fifo_rd_data);

   // ------------------------------------------------------- raster counters
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          h_wrap, v_wrap;
   logic          active, hs_on, vs_on;
   logic          exp_sof, exp_eol;

   assign h_wrap = (h_cnt_q == HW'(H_TOTAL - 1));
   assign v_wrap = (v_cnt_q == VW'(V_TOTAL - 1));

   always_comb begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
   end

   assign active  = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
   assign hs_on   = (int'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                    (int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
   assign vs_on   = (int'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                    (int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);
   assign exp_sof = (h_cnt_q == '0) && (v_cnt_q == '0);
   assign exp_eol = (h_cnt_q == HW'(H_ACTIVE - 1));

   // ------------------------------------------------------- lock FSM
   vid_state_e       state_q, state_d;
   logic [RGB_W-1:0] pix_d;
   logic             underflow_d;
   logic             resync_d;

   always_ff @(posedge vid_aclk or negedge vid_aresetn) begin
      if (!vid_aresetn) state_q <= WAIT_SOF;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      fifo_pop    = 1'b0;
      pix_d       = '0;
      underflow_d = 1'b0;
      resync_d    = 1'b0;
      unique case (state_q)
         WAIT_SOF: begin
            // Drain everything ahead of the next start-of-frame; keep the SOF beat.
            if (!fifo_empty) begin
               if (head.sof) state_d  = WAIT_FRAME;
               else          fifo_pop = 1'b1;
            end
         end
         WAIT_FRAME: begin
            // Hold the SOF beat until the raster is about to re-enter (0,0).
            if (h_wrap && v_wrap) state_d = LOCKED;
         end
         LOCKED: begin
            if (active) begin
               if (fifo_empty) begin
                  underflow_d = 1'b1;
                  state_d     = WAIT_SOF;
               end else begin
                  fifo_pop = 1'b1;
                  if ((head.sof != exp_sof) || (head.eol != exp_eol)) begin
                     resync_d = 1'b1;
                     state_d  = WAIT_SOF;
                  end else begin
                     pix_d = head.rgb;
                  end
               end
            end
         end
         default: state_d = WAIT_SOF;
      endcase
   end

   // ------------------------------------------------------- output registers
   logic             de_q, hsync_q, vsync_q, locked_q, underflow_q, resync_q;
   logic [RGB_W-1:0] data_q;

   always_ff @(posedge vid_aclk or negedge vid_aresetn) begin
      if (!vid_aresetn) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         de_q        <= 1'b0;
         hsync_q     <= ~HSYNC_POL;
         vsync_q     <= ~VSYNC_POL;
         data_q      <= '0;
         locked_q    <= 1'b0;
         underflow_q <= 1'b0;
         resync_q    <= 1'b0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         de_q        <= active;
         hsync_q     <= hs_on ? HSYNC_POL : ~HSYNC_POL;
         vsync_q     <= vs_on ? VSYNC_POL : ~VSYNC_POL;
         data_q      <= pix_d;
         locked_q    <= (state_d == LOCKED);
         underflow_q <= underflow_d;
         resync_q    <= resync_d;
      end
   end

   assign vid_de     = de_q;
   assign vid_hsync  = hsync_q;
   assign vid_vsync  = vsync_q;
   assign vid_data   = data_q;
   assign locked     = locked_q;
   assign underflow  = underflow_q;
   assign resync_err = resync_q;

endmodule

// File: tb/tb_axis_video_out.sv
module tb_axis_video_out;

   localparam int HA = 4, HF = 1, HS = 2, HB = 1;
   localparam int VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int DEPTH = 4;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int M_SOF = 0, M_FRAME = 1, M_LOCK = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] tdata = '0;
   logic        tuser = 1'b0, tlast = 1'b0, tvalid = 1'b0;
   logic        tready;
   logic [23:0] vdata;
   logic        de, hs, vs, lock_o, uf, re;

   always #5 clk = ~clk;

   axis_video_out #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FIFO_DEPTH(DEPTH)
   ) dut (
      .vid_aclk(clk), .vid_aresetn(rst_n),
      .s_axis_vid_tdata(tdata), .s_axis_vid_tuser(tuser),
      .s_axis_vid_tlast(tlast), .s_axis_vid_tvalid(tvalid),
      .s_axis_vid_tready(tready),
      .vid_data(vdata), .vid_de(de), .vid_hsync(hs), .vid_vsync(vs),
      .locked(lock_o), .underflow(uf), .resync_err(re)
   );

   typedef struct { bit user; bit last; bit [31:0] data; } beat_t;

   beat_t       stim_q[$];
   // reference: queue holds {sof, eol, rgb} of accepted beats
   bit [25:0]   mq[$];
   int          mode;
   int unsigned cyc;
   bit          ready_m;
   bit          exp_de, exp_hs, exp_vs, exp_lock, exp_uf, exp_re;
   bit [23:0]   exp_data;
   int          valid_pct;

   int          n_checks = 0, n_fail = 0;
   int          n_uf, n_re, n_tr0, n_hs0, n_vs0, n_de, n_nz, n_lock, lock_at;
   bit [23:0]   seen_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      logic [30:0] want;
      want = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0};
      chk(tag, {tready, de, hs, vs, lock_o, uf, re, vdata}, want);
   endtask

   task automatic model_reset();
      mq.delete();
      mode = M_SOF; cyc = 0; ready_m = 1'b0;
      exp_de = 0; exp_hs = 1; exp_vs = 1; exp_lock = 0; exp_uf = 0; exp_re = 0;
      exp_data = '0;
   endtask

   task automatic clear_stats();
      n_uf = 0; n_re = 0; n_tr0 = 0; n_hs0 = 0; n_vs0 = 0; n_de = 0;
      n_nz = 0; n_lock = 0; lock_at = -1;
      seen_q.delete();
   endtask

   // One clock edge of the reference: raster position from the absolute cycle
   // index, FIFO as a queue, lock rules applied to the queue head.
   task automatic model_edge();
      int        h, v, nxt;
      bit        act, pop;
      bit [25:0] hd;
      h   = int'(cyc % HT);
      v   = int'((cyc / HT) % VT);
      act = (h < HA) && (v < VA);
      exp_de = act;
      exp_hs = !(h >= HA + HF && h < HA + HF + HS);
      exp_vs = !(v >= VA + VF && v < VA + VF + VS);
      exp_data = '0; exp_uf = 0; exp_re = 0; pop = 0; nxt = mode;
      hd = (mq.size() > 0) ? mq[0] : '0;
      if (mode == M_SOF) begin
         if (mq.size() > 0) begin
            if (hd[25]) nxt = M_FRAME;
            else        pop = 1;
         end
      end else if (mode == M_FRAME) begin
         if (h == HT - 1 && v == VT - 1) nxt = M_LOCK;
      end else if (act) begin
         if (mq.size() == 0) begin
            exp_uf = 1; nxt = M_SOF;
         end else begin
            pop = 1;
            if ((hd[25] != (h == 0 && v == 0)) || (hd[24] != (h == HA - 1))) begin
               exp_re = 1; nxt = M_SOF;
            end else begin
               exp_data = hd[23:0];
            end
         end
      end
      if (pop) void'(mq.pop_front());
      if (tvalid && ready_m) mq.push_back({tuser, tlast, tdata[31:8]});
      ready_m  = (mq.size() < DEPTH);
      mode     = nxt;
      cyc++;
      exp_lock = (mode == M_LOCK);
   endtask

   task automatic step();
      bit acc;
      if (stim_q.size() > 0 && $urandom_range(99) < valid_pct) begin
         tvalid = 1'b1; tuser = stim_q[0].user; tlast = stim_q[0].last;
         tdata  = stim_q[0].data;
      end else begin
         tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; tdata = $urandom;
      end
      acc = tvalid && ready_m;
      @(posedge clk);
      model_edge();
      if (acc) void'(stim_q.pop_front());
      #1;
      chk($sformatf("cyc%0d {rdy,de,hs,vs,lock,uf,re,data}", cyc - 1),
          {tready, de, hs, vs, lock_o, uf, re, vdata},
          {ready_m, exp_de, exp_hs, exp_vs, exp_lock, exp_uf, exp_re, exp_data});
      if (uf) n_uf++;
      if (re) n_re++;
      if (!tready) n_tr0++;
      if (!hs) n_hs0++;
      if (!vs) n_vs0++;
      if (de) n_de++;
      if (vdata != '0) n_nz++;
      if (lock_o) n_lock++;
      if (lock_o && lock_at < 0) lock_at = int'(cyc);
      if (de && lock_o) seen_q.push_back(vdata);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
      stim_q.delete(); model_reset(); clear_stats();
      #1 chk_reset_values("reset_values");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic add_frame(input bit bad, input bit rnd, input int npix);
      for (int p = 1; p <= npix; p++) begin
         beat_t    b;
         bit [7:0] i8;
         i8     = 8'(p);
         b.user = (p == 1);
         b.last = bad ? (p == 3 || p == 8 || p == 12) : (p % 4 == 0);
         b.data = rnd ? $urandom : {i8, i8, i8, 8'h00};
         stim_q.push_back(b);
      end
   endtask

   task automatic chk_seq(input string tag, input int n);
      chk({tag, "_count"}, seen_q.size(), n);
      for (int i = 0; i < n && i < seen_q.size(); i++) begin
         bit [7:0] p;
         p = 8'(i % 12 + 1);
         chk($sformatf("%s_px%0d", tag, i), seen_q[i], {p, p, p});
      end
   endtask

   initial begin
      valid_pct = 100;

      // 1: idle raster
      do_reset();
      repeat (48) step();
      chk("s1_hsync_low", n_hs0, 12);
      chk("s1_de_high", n_de, 12);
      chk("s1_vsync_low", n_vs0, 8);
      chk("s1_data_nonzero", n_nz, 0);
      chk("s1_locked", n_lock, 0);

      // 2: one clean frame
      do_reset();
      add_frame(0, 0, 12);
      repeat (96) step();
      chk("s2_lock_at", lock_at, 48);
      chk_seq("s2", 12);
      chk("s2_underflow", n_uf, 0);
      chk("s2_resync", n_re, 0);

      // 3: junk ahead of the frame
      do_reset();
      for (int j = 0; j < 5; j++) begin
         beat_t b;
         b.user = 0; b.last = 1'($urandom_range(1)); b.data = $urandom;
         stim_q.push_back(b);
      end
      add_frame(0, 0, 12);
      repeat (8) step();
      chk("s3_tready_during_junk", n_tr0, 0);
      repeat (88) step();
      chk("s3_lock_at", lock_at, 48);
      chk_seq("s3", 12);
      chk("s3_errors", n_uf + n_re, 0);

      // 4: stream stops after pixel 6, then a full frame
      do_reset();
      add_frame(0, 0, 6);
      repeat (96) step();
      chk("s4_underflow", n_uf, 1);
      chk("s4_pixels_before_uf", seen_q.size(), 6);
      add_frame(0, 0, 12);
      repeat (96) step();
      chk("s4_relock_pixels", seen_q.size(), 18);
      if (seen_q.size() > 6) chk("s4_relock_first", seen_q[6], 24'h010101);
      chk("s4_underflow_total", n_uf, 1);
      chk("s4_resync", n_re, 0);

      // 5: misplaced tlast, relock, then asynchronous reset mid-frame
      do_reset();
      add_frame(1, 0, 12);
      add_frame(0, 0, 12);
      for (int i = 0; i < 400 && !(exp_lock && exp_data == 24'h080808); i++) step();
      chk("s5_resync", n_re, 1);
      chk("s5_underflow", n_uf, 0);
      chk("s5_pixel8_data", vdata, 24'h080808);
      chk("s5_pixel8_locked", lock_o, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk_reset_values("s5_async_reset");
      model_reset();

      // 6: three back-to-back frames, upstream always valid
      do_reset();
      add_frame(0, 0, 12);
      add_frame(0, 0, 12);
      add_frame(0, 0, 12);
      repeat (192) step();
      chk_seq("s6", 36);
      chk("s6_tready_low_seen", n_tr0 > 0, 1'b1);
      chk("s6_errors", n_uf + n_re, 0);

      // 7: random payloads, random gaps, occasional bad framing and junk
      do_reset();
      for (int f = 0; f < 6; f++) begin
         if ($urandom_range(3) == 0) begin
            beat_t b;
            b.user = 0; b.last = 0; b.data = $urandom;
            stim_q.push_back(b);
         end
         add_frame($urandom_range(4) == 0, 1, 12);
      end
      valid_pct = 85 + int'($urandom_range(15));
      repeat (400) step();
      valid_pct = 100;

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
